// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with 2-bit saturating direction counters.
//
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-low reset
//   pc_if0, fetch_valid      IF0 lookup request
//   pre_branch, pre_pc       zero-latency prediction for the IF0 PC
//   ex_*                     EX-stage resolution used to check the prediction and train the BTB
//   mispredict, redirect_pc  redirect request and the correct next PC
//   branch_cnt, mispred_cnt  saturating statistics counters
module branch_predictor #(
   parameter int unsigned WORD    = 32,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [WORD-1:0] pc_if0,
   input  logic            fetch_valid,
   output logic            pre_branch,
   output logic [WORD-1:0] pre_pc,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [WORD-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [WORD-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [WORD-1:0] ex_pred_pc,
   output logic            mispredict,
   output logic [WORD-1:0] redirect_pc,
   output logic [31:0]     branch_cnt,
   output logic [31:0]     mispred_cnt
);

   localparam int unsigned     TAG_W   = WORD - IDX_W - 2;
   localparam logic [WORD-1:0] PC_STEP = WORD'(4);

   logic [ENTRIES-1:0]      valid_q;
   logic [ENTRIES-1:0][1:0] ctr_q;
   logic [TAG_W-1:0]        tag_q    [ENTRIES];
   logic [WORD-1:0]         target_q [ENTRIES];
   logic [31:0]             branch_cnt_q;
   logic [31:0]             mispred_cnt_q;

   // ---------------- Lookup ----------------
   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   assign if_idx = pc_if0[IDX_W+1:2];
   assign if_tag = pc_if0[WORD-1:IDX_W+2];
   assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

   // Reads registered tables only: a same-cycle update is visible next cycle.
   assign pre_branch = rst && fetch_valid && if_hit && ctr_q[if_idx][1];
   assign pre_pc     = pre_branch ? target_q[if_idx] : pc_if0 + PC_STEP;

   // ---------------- Resolution ----------------
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;
   logic             ex_act;
   logic             ex_branch;

   assign ex_idx    = ex_pc[IDX_W+1:2];
   assign ex_tag    = ex_pc[WORD-1:IDX_W+2];
   assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign ex_act    = rst && ex_valid;
   assign ex_branch = ex_act && ex_is_branch;

   // A non-branch carrying a taken prediction is caught by the direction term (ex_taken=0).
   assign mispredict = ex_act && ((ex_taken != ex_pred_taken) ||
                                  (ex_taken && (ex_target != ex_pred_pc)));

   always_comb begin
      redirect_pc = '0;
      if (ex_act) begin
         redirect_pc = (mispredict && ex_taken) ? ex_target : ex_pc + PC_STEP;
      end
   end

   // ---------------- Table update decode ----------------
   logic       val_we;
   logic       val_new;
   logic       ctr_we;
   logic [1:0] ctr_new;
   logic       tag_we;
   logic       tgt_we;

   always_comb begin
      val_we  = 1'b0;
      val_new = 1'b0;
      ctr_we  = 1'b0;
      ctr_new = ctr_q[ex_idx];
      tag_we  = 1'b0;
      tgt_we  = 1'b0;
      if (ex_branch) begin
         if (ex_hit) begin
            ctr_we = 1'b1;
            if (ex_taken) begin
               tgt_we = 1'b1;
               if (ctr_q[ex_idx] != 2'b11) ctr_new = ctr_q[ex_idx] + 2'b01;
            end else if (ctr_q[ex_idx] != 2'b00) begin
               ctr_new = ctr_q[ex_idx] - 2'b01;
            end
         end else if (ex_taken) begin
            // Allocate, evicting whatever aliased entry held this index.
            val_we  = 1'b1;
            val_new = 1'b1;
            tag_we  = 1'b1;
            tgt_we  = 1'b1;
            ctr_we  = 1'b1;
            ctr_new = 2'b10;
         end
      end else if (ex_act && ex_pred_taken && ex_hit) begin
         // Stale entry predicted a branch at a non-branch PC: drop it.
         val_we  = 1'b1;
         val_new = 1'b0;
      end
   end

   // ---------------- State ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         ctr_q   <= {ENTRIES{2'b01}};
      end else begin
         if (val_we) valid_q[ex_idx] <= val_new;
         if (ctr_we) ctr_q[ex_idx]   <= ctr_new;
      end
   end

   // Tag/target need no reset: they are only observed through a set valid bit.
   always_ff @(posedge clk) begin
      if (tag_we) tag_q[ex_idx]    <= ex_tag;
      if (tgt_we) target_q[ex_idx] <= ex_target;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (ex_branch && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + 32'd1;
         if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed test-plan steps followed by random
// traffic, all compared against a table-level behavioural model.
module tb_branch_predictor;

   localparam int unsigned ENTRIES = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_if0 = '0;
   logic        fetch_valid = 1'b0;
   logic        pre_branch;
   logic [31:0] pre_pc;
   logic        ex_valid = 1'b0;
   logic        ex_is_branch = 1'b0;
   logic [31:0] ex_pc = '0;
   logic        ex_taken = 1'b0;
   logic [31:0] ex_target = '0;
   logic        ex_pred_taken = 1'b0;
   logic [31:0] ex_pred_pc = '0;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   int checks = 0;
   int errors = 0;

   branch_predictor #(.WORD(32), .ENTRIES(ENTRIES)) dut (
      .clk(clk), .rst(rst), .pc_if0(pc_if0), .fetch_valid(fetch_valid),
      .pre_branch(pre_branch), .pre_pc(pre_pc), .ex_valid(ex_valid),
      .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc), .mispredict(mispredict),
      .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- Reference model ----------------
   bit          m_valid  [ENTRIES];
   logic [31:0] m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   longint      m_bcnt;
   longint      m_mcnt;

   function automatic int unsigned m_idx(input logic [31:0] pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic logic [31:0] m_tagof(input logic [31:0] pc);
      return pc / (4 * ENTRIES);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
   endfunction

   function automatic bit m_mis();
      if (!(rst && ex_valid)) return 1'b0;
      return (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_pc));
   endfunction

   task automatic m_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
      m_bcnt = 0;
      m_mcnt = 0;
   endtask

   task automatic m_update();
      int unsigned i;
      i = m_idx(ex_pc);
      if (!ex_valid) return;
      if (m_mis() && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
      if (ex_is_branch) begin
         if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
         if (m_hit(ex_pc)) begin
            m_ctr[i] = ex_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (ex_taken) m_target[i] = ex_target;
         end else if (ex_taken) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = m_tagof(ex_pc);
            m_target[i] = ex_target;
            m_ctr[i]    = 2;
         end
      end else if (ex_pred_taken && m_hit(ex_pc)) begin
         m_valid[i] = 1'b0;
      end
   endtask

   // ---------------- Checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      bit          pb;
      logic [31:0] pp;
      logic [31:0] rp;
      bit          mis;
      pb  = rst && fetch_valid && m_pred(pc_if0);
      pp  = pb ? m_target[m_idx(pc_if0)] : pc_if0 + 32'd4;
      mis = m_mis();
      rp  = !(rst && ex_valid) ? 32'd0 : (mis && ex_taken) ? ex_target : ex_pc + 32'd4;
      chk({tag, ".pre_branch"}, {31'd0, pre_branch}, {31'd0, pb});
      chk({tag, ".pre_pc"}, pre_pc, pp);
      chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, mis});
      chk({tag, ".redirect_pc"}, redirect_pc, rp);
      chk({tag, ".branch_cnt"}, branch_cnt, m_bcnt[31:0]);
      chk({tag, ".mispred_cnt"}, mispred_cnt, m_mcnt[31:0]);
   endtask

   task automatic set_fetch(input logic v, input logic [31:0] pc);
      fetch_valid = v;
      pc_if0      = pc;
   endtask

   task automatic set_ex(input logic v, input logic br, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ppc);
      ex_valid      = v;
      ex_is_branch  = br;
      ex_pc         = pc;
      ex_taken      = tk;
      ex_target     = tgt;
      ex_pred_taken = ptk;
      ex_pred_pc    = ppc;
   endtask

   task automatic ex_idle();
      set_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   // Inputs are driven just after a rising edge; outputs are sampled on the falling edge.
   task automatic settle(input string tag);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      m_update();
      #1;
   endtask

   // EX resolution of pc using the model's current prediction as the carried prediction.
   task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      bit p;
      p = m_pred(pc);
      set_ex(1'b1, 1'b1, pc, tk, tgt, p, p ? m_target[m_idx(pc)] : pc + 32'd4);
   endtask

   function automatic logic [31:0] rnd_pc();
      logic [31:0] base;
      case ($urandom_range(0, 3))
         0:       base = 32'h1C00_0000;
         1:       base = 32'h1C00_0040;
         2:       base = 32'h1C00_0400;
         default: base = 32'hFFFF_FFC0;
      endcase
      return base + 32'($urandom_range(0, 15)) * 32'd4;
   endfunction

   function automatic logic [31:0] rnd_tgt();
      case ($urandom_range(0, 3))
         0:       return 32'h1C00_0100;
         1:       return 32'h1C00_0200;
         2:       return rnd_pc();
         default: return $urandom;
      endcase
   endfunction

   task automatic random_cycles(input int n);
      logic [31:0] epc;
      logic        br;
      logic        tk;
      for (int k = 0; k < n; k++) begin
         set_fetch(1'($urandom_range(0, 7) != 0), rnd_pc());
         epc = rnd_pc();
         br  = 1'($urandom_range(0, 3) != 0);
         tk  = br ? 1'($urandom_range(0, 1)) : 1'b0;
         if ($urandom_range(0, 1) == 1) begin
            resolve(epc, tk, rnd_tgt());
            ex_is_branch = br;
         end else begin
            set_ex(1'b1, br, epc, tk, rnd_tgt(), 1'($urandom_range(0, 1)), rnd_tgt());
         end
         if ($urandom_range(0, 5) == 0) ex_valid = 1'b0;
         settle("rand");
         tick();
      end
   endtask

   initial begin
      m_reset();
      // Reset values
      set_fetch(1'b1, 32'h1C00_0000);
      ex_idle();
      #3;
      chk("rst.pre_branch", {31'd0, pre_branch}, 32'd0);
      chk("rst.pre_pc", pre_pc, 32'h1C00_0004);
      chk("rst.mispredict", {31'd0, mispredict}, 32'd0);
      chk("rst.redirect_pc", redirect_pc, 32'd0);
      chk("rst.branch_cnt", branch_cnt, 32'd0);
      chk("rst.mispred_cnt", mispred_cnt, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // First taken branch: mispredicted, allocated
      set_fetch(1'b1, 32'h1C00_0000);
      set_ex(1'b1, 1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0100, 1'b0, 32'h1C00_0014);
      settle("alloc");
      chk("alloc.mispredict", {31'd0, mispredict}, 32'd1);
      chk("alloc.redirect_pc", redirect_pc, 32'h1C00_0100);
      tick();
      set_fetch(1'b1, 32'h1C00_0010);
      ex_idle();
      settle("hit");
      chk("hit.pre_branch", {31'd0, pre_branch}, 32'd1);
      chk("hit.pre_pc", pre_pc, 32'h1C00_0100);
      chk("hit.branch_cnt", branch_cnt, 32'd1);
      chk("hit.mispred_cnt", mispred_cnt, 32'd1);
      tick();

      // Three not-taken: 10 -> 01 -> 00 -> 00, same-cycle lookup sees pre-update state
      resolve(32'h1C00_0010, 1'b0, 32'h1C00_0100);
      settle("nt1");
      chk("nt1.same_cycle_pre_branch", {31'd0, pre_branch}, 32'd1);
      chk("nt1.mispredict", {31'd0, mispredict}, 32'd1);
      tick();
      resolve(32'h1C00_0010, 1'b0, 32'h1C00_0100);
      settle("nt2");
      chk("nt2.next_cycle_pre_branch", {31'd0, pre_branch}, 32'd0);
      chk("nt2.mispredict", {31'd0, mispredict}, 32'd0);
      chk("nt2.redirect_pc", redirect_pc, 32'h1C00_0014);
      tick();
      resolve(32'h1C00_0010, 1'b0, 32'h1C00_0100);
      settle("nt3");
      chk("nt3.mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      // From 00 one taken gives 01 (still not taken); a second gives 10
      resolve(32'h1C00_0010, 1'b1, 32'h1C00_0100);
      settle("tk1");
      tick();
      resolve(32'h1C00_0010, 1'b1, 32'h1C00_0100);
      settle("tk2");
      chk("ctr01.pre_branch", {31'd0, pre_branch}, 32'd0);
      tick();
      ex_idle();
      settle("ctr10");
      chk("ctr10.pre_branch", {31'd0, pre_branch}, 32'd1);
      chk("ctr10.pre_pc", pre_pc, 32'h1C00_0100);
      tick();

      // Aliasing on index 4
      set_fetch(1'b1, 32'h1C00_0050);
      resolve(32'h1C00_0050, 1'b1, 32'h1C00_0200);
      settle("alias");
      chk("alias.pre_branch", {31'd0, pre_branch}, 32'd0);
      chk("alias.pre_pc", pre_pc, 32'h1C00_0054);
      tick();
      ex_idle();
      settle("alias_new");
      chk("alias_new.pre_pc", pre_pc, 32'h1C00_0200);
      tick();
      set_fetch(1'b1, 32'h1C00_0010);
      settle("alias_evicted");
      chk("alias_evicted.pre_branch", {31'd0, pre_branch}, 32'd0);
      chk("alias_evicted.pre_pc", pre_pc, 32'h1C00_0014);
      tick();

      // Non-branch at a tag-hitting PC predicted taken
      resolve(32'h1C00_0010, 1'b1, 32'h1C00_0100);
      settle("realloc");
      tick();
      set_ex(1'b1, 1'b0, 32'h1C00_0010, 1'b0, 32'h1C00_0100, 1'b1, 32'h1C00_0100);
      settle("nonbr");
      chk("nonbr.mispredict", {31'd0, mispredict}, 32'd1);
      chk("nonbr.redirect_pc", redirect_pc, 32'h1C00_0014);
      tick();
      ex_idle();
      settle("nonbr_inval");
      chk("nonbr_inval.pre_branch", {31'd0, pre_branch}, 32'd0);
      tick();

      random_cycles(400);

      // Mid-run asynchronous reset while predicting taken and mispredicting
      ex_idle();
      resolve(32'h1C00_0030, 1'b1, 32'h1C00_0300);
      settle("pre_rst_a");
      tick();
      resolve(32'h1C00_0030, 1'b1, 32'h1C00_0300);
      settle("pre_rst_b");
      tick();
      set_fetch(1'b1, 32'h1C00_0030);
      set_ex(1'b1, 1'b1, 32'h1C00_0030, 1'b1, 32'h1C00_0300, 1'b0, 32'h1C00_0034);
      settle("pre_rst");
      chk("pre_rst.pre_branch", {31'd0, pre_branch}, 32'd1);
      chk("pre_rst.mispredict", {31'd0, mispredict}, 32'd1);
      #1;
      rst = 1'b0;
      m_reset();
      #1;
      chk("async_rst.pre_branch", {31'd0, pre_branch}, 32'd0);
      chk("async_rst.pre_pc", pre_pc, 32'h1C00_0034);
      chk("async_rst.mispredict", {31'd0, mispredict}, 32'd0);
      chk("async_rst.redirect_pc", redirect_pc, 32'd0);
      chk("async_rst.branch_cnt", branch_cnt, 32'd0);
      chk("async_rst.mispred_cnt", mispred_cnt, 32'd0);
      @(posedge clk);
      #1;
      ex_idle();
      rst = 1'b1;
      settle("post_rst");
      chk("post_rst.pre_branch", {31'd0, pre_branch}, 32'd0);
      chk("post_rst.pre_pc", pre_pc, 32'h1C00_0034);
      tick();
      set_fetch(1'b1, 32'h1C00_0050);
      settle("post_rst_miss");
      chk("post_rst_miss.pre_pc", pre_pc, 32'h1C00_0054);
      tick();

      random_cycles(300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Prediction/resolution end of the fetch-redirect interface.
- Provides pre_branch/pre_pc to IF0 from a direct-mapped BTB with 2-bit saturating counters.
- Consumes EX-stage resolution (ex_taken/ex_target) to train the tables.
- Flags mispredictions, supplies the redirect PC, and keeps branch and mispredict statistics counters.

Parameters:
- WORD, 32, datapath/PC width.
- ENTRIES, 16, BTB entries; power of two, at least 2.
- IDX_W, log2(ENTRIES), index width. Index = PC[IDX_W+1:2]; tag = PC[WORD-1:IDX_W+2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_if0  in  WORD  PC being fetched in IF0.
- fetch_valid  in  1  pc_if0 is valid.
- pre_branch  out  1  predicted taken.
- pre_pc  out  WORD  predicted next PC.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_branch  in  1  EX instruction is a branch or jump.
- ex_pc  in  WORD  PC of the EX instruction.
- ex_taken  in  1  resolved direction; 0 when not a branch.
- ex_target  in  WORD  resolved target.
- ex_pred_taken  in  1  prediction carried with the instruction.
- ex_pred_pc  in  WORD  predicted PC carried with the instruction.
- mispredict  out  1  redirect required.
- redirect_pc  out  WORD  correct next PC.
- branch_cnt  out  32  resolved-branch count.
- mispred_cnt  out  32  misprediction count.

Behaviour:
- Storage per entry: valid bit, tag, WORD-bit target, 2-bit counter.
- Reset (rst=0, asynchronous, may occur mid-operation):
  - all valid bits cleared; counters set to 2'b01 (weakly not-taken); branch_cnt=0, mispred_cnt=0.
  - Outputs during reset: pre_branch=0, pre_pc=pc_if0+4, mispredict=0, redirect_pc=0.
- Lookup (combinational from registered tables, zero latency):
  - hit = valid[idx] and tag match.
  - If fetch_valid, hit and ctr[1]: pre_branch=1, pre_pc=target.
  - Otherwise: pre_branch=0, pre_pc=pc_if0+4, wrapping modulo 2^WORD.
- Resolution (combinational, gated by ex_valid and rst=1):
  - mispredict = (ex_taken != ex_pred_taken) OR (ex_taken AND ex_target != ex_pred_pc).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - When mispredict=0: redirect_pc = ex_pc+4 if ex_valid, else 0.
- Update (registered at the clock edge; only one per cycle).
  - Branch (ex_valid and ex_is_branch), EX-index hit:
    - counter increments if taken, saturating at 2'b11; decrements if not taken, saturating at 2'b00;
    - target overwritten with ex_target when taken.
  - Branch, EX-index miss:
    - taken: allocate, replacing any aliased entry. Set valid=1, tag, target=ex_target, ctr=2'b10.
    - not taken: no change.
  - Non-branch (ex_valid, ex_is_branch=0) with ex_pred_taken=1:
    - mispredict=1, redirect ex_pc+4;
    - if the entry tag-hits, clear its valid bit.
- Simultaneous lookup and update of the same index: lookup returns pre-update contents; no bypass. The new contents are visible the following cycle.
- Statistics counters:
  - branch_cnt +1 on each ex_valid and ex_is_branch cycle.
  - mispred_cnt +1 on each mispredict cycle.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
- No stall input. EX inputs are sampled every cycle; upstream must hold ex_valid=0 for bubbles.

Test Plan:
- Reset, then pc_if0=0x1C000000, fetch_valid=1 -> pre_branch=0, pre_pc=0x1C000004, branch_cnt=0, mispred_cnt=0.
- EX: ex_pc=0x1C000010, branch, ex_taken=1, ex_target=0x1C000100, ex_pred_taken=0:
  - same cycle: mispredict=1, redirect_pc=0x1C000100;
  - next cycle: mispred_cnt=1, branch_cnt=1; pc_if0=0x1C000010 -> pre_branch=1, pre_pc=0x1C000100.
- Three not-taken resolutions of 0x1C000010 (ex_pred_taken matching the current prediction):
  - counter steps 10 -> 01 -> 00 -> 00;
  - pre_branch=0 after the first;
  - mispredict=1 only on the first.
- Aliasing: 0x1C000050 shares index 4 with 0x1C000010 (different tag):
  - lookup misses -> pre_pc=0x1C000054;
  - taken resolution to 0x1C000200 replaces the entry; 0x1C000010 then misses.
- Non-branch at tag-hitting 0x1C000010 with ex_pred_taken=1:
  - mispredict=1, redirect_pc=0x1C000014;
  - next cycle the lookup of 0x1C000010 returns pre_branch=0.
- Edge cases:
  - Same-cycle update and lookup of 0x1C000010 -> pre-update prediction that cycle, updated prediction the next.
  - Assert rst=0 mid-run -> outputs go to reset values without waiting for a clock edge; all entries miss afterwards.
